priority_event_queue: RTL and testbench
=======================================

PRIORITY_EVENT_QUEUE -- requirements
Module: priority_event_queue

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: encoded_code  input  2  index from the upstream 4-to-2 priority encoder (data bit 1 = MSB).
REQ-005 Port: encoded_valid  input  1  upstream valid flag; encoded_code ignored when 0.
REQ-006 Port: event_code  output  2  code of FIFO head entry.
REQ-007 Port: event_valid  output  1  FIFO non-empty; event_code meaningful.
REQ-008 Port: event_ready  input  1  consumer accepts head when high with event_valid.
REQ-009 Port: fifo_count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-010 Port: overflow_flag  output  1  sticky; an event was dropped because the FIFO was full.
REQ-011 Port: overflow_clear  input  1  clears overflow_flag.

Function
REQ-012 Block SHALL register encoded_valid and encoded_code each cycle into prev_valid/prev_code.
REQ-013 Capture event SHALL occur in a cycle where encoded_valid=1 and (prev_valid=0 or encoded_code != prev_code).
REQ-014 Steady encoded_valid=1 with unchanged code SHALL produce exactly one event; valid dropping to 0 SHALL produce none.
REQ-015 Push = capture event and (count<DEPTH or pop in same cycle).
REQ-016 Pop = event_valid and event_ready.
REQ-017 Pushed entry SHALL appear on event_code/event_valid at earliest one cycle after the capture cycle; no combinational bypass.
REQ-018 Entries SHALL be delivered in capture order; head SHALL remain stable while event_valid=1 and event_ready=0.
REQ-019 event_valid SHALL equal (fifo_count != 0); both registered.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged, including at full and at count=1.
REQ-021 Push with count=0 and event_ready=1 SHALL NOT pop the new entry in the same cycle.
REQ-022 Capture event at count=DEPTH without pop SHALL be dropped, FIFO contents unchanged, overflow_flag set next cycle.
REQ-023 overflow_clear SHALL clear overflow_flag next cycle; a drop in the same cycle SHALL win (flag stays 1).
REQ-024 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-025 Pop with count=0 SHALL have no effect.

Reset
REQ-026 reset=1 at a rising edge SHALL set fifo_count=0, event_valid=0, event_code=2'b00, overflow_flag=0, pointers=0, prev_valid=0, prev_code=2'b00.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; capture/push/pop in that cycle SHALL be ignored.
REQ-028 First cycle after reset release with encoded_valid=1 SHALL be a capture event.

Configuration
REQ-029 Macro PRIORITY_EVENT_DEDUP_EN SHALL select duplicate suppression.
REQ-030 With PRIORITY_EVENT_DEDUP_EN defined: capture event SHALL be discarded (no push, no overflow) when encoded_code equals the code of the last pushed entry; last-pushed register reset to "none", so first event after reset always pushes.
REQ-031 Without PRIORITY_EVENT_DEDUP_EN: every capture event per REQ-013 SHALL be pushed; no last-pushed register exists.

Verification
REQ-032 Sequence: encoded_valid=1 code 2'b11 held 5 cycles, event_ready=0 -> fifo_count=1, event_code=2'b11, event_valid=1 from cycle 2.
REQ-033 Sequence: codes 01,10,11,00 back-to-back valid, event_ready=1 from cycle 6 -> pops in order 01,10,11,00, fifo_count 4->0.
REQ-034 Sequence: 5 distinct changes with event_ready=0, DEPTH=4 -> fifo_count=4, 5th dropped, overflow_flag=1; overflow_clear with simultaneous drop -> flag stays 1.
REQ-035 Sequence: full FIFO, event_ready=1 and new capture same cycle -> fifo_count stays 4, head advances, new entry at tail.
REQ-036 Sequence: 3 entries stored, reset for 1 cycle -> fifo_count=0, event_valid=0, overflow_flag=0 next cycle.
REQ-037 Sequence: codes 11, invalid, 11 -> two pushes without PRIORITY_EVENT_DEDUP_EN; one push with it.

Source files
------------

// File: rtl/priority_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : priority_event_queue
//  Description : Turns the output of an upstream 4-to-2 priority encoder into
//                a stream of events. A new event is captured when the valid
//                flag rises or when the code changes while valid. Captured
//                events go into a small FIFO that keeps arrival order.
//                The FIFO sets a sticky overflow flag when it drops an event.
//                Optional macro PRIORITY_EVENT_DEDUP_EN: a capture whose
//                code equals the last pushed code is discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_event_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               encoded_code,
  input  logic                     encoded_valid,
  output logic [1:0]               event_code,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow_flag,
  input  logic                     overflow_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Registered state
  logic             prev_valid_q, prev_valid_d;
  logic [1:0]       prev_code_q,  prev_code_d;
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic             overflow_q,   overflow_d;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];

  // Internal decode
  logic capture;
  logic accept;
  logic pop;
  logic push;
  logic drop;
  logic full;

`ifdef PRIORITY_EVENT_DEDUP_EN
  // Remembers the code of the most recent pushed entry; "none" after reset
  logic       last_valid_q, last_valid_d;
  logic [1:0] last_code_q,  last_code_d;
`endif

  // Edge-style capture on the upstream valid/code pair
  always_comb begin
    capture = encoded_valid && (!prev_valid_q || (encoded_code != prev_code_q));
`ifdef PRIORITY_EVENT_DEDUP_EN
    accept  = capture && !(last_valid_q && (last_code_q == encoded_code));
`else
    accept  = capture;
`endif
    full    = (count_q == FULL_COUNT);
    pop     = (count_q != '0) && event_ready;
    push    = accept && (!full || pop);
    drop    = accept && full && !pop;
  end

  // Next-state for pointers, occupancy, storage and overflow flag
  always_comb begin
    prev_valid_d = encoded_valid;
    prev_code_d  = encoded_code;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = encoded_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A simultaneous push and pop leaves the occupancy unchanged
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // A drop in the same cycle as a clear keeps the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

`ifdef PRIORITY_EVENT_DEDUP_EN
  // Track the last pushed code for duplicate suppression
  always_comb begin
    last_valid_d = last_valid_q;
    last_code_d  = last_code_q;
    if (push) begin
      last_valid_d = 1'b1;
      last_code_d  = encoded_code;
    end
  end

  // Last-pushed register; reset means "nothing pushed yet"
  always_ff @(posedge clock) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_code_q  <= 2'b00;
    end else begin
      last_valid_q <= last_valid_d;
      last_code_q  <= last_code_d;
    end
  end
`endif

  // State register; reset discards everything including this cycle's traffic
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_valid_q <= 1'b0;
      prev_code_q  <= 2'b00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_code_q  <= prev_code_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
    end
  end

  // Outputs come straight from registers; the storage is cleared on reset so
  // the head reads 2'b00 afterwards
  assign event_code    = mem_q[rd_ptr_q];
  assign event_valid   = (count_q != '0);
  assign fifo_count    = count_q;
  assign overflow_flag = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_event_queue
//  Description : Directed, table-driven checks for priority_event_queue
//                (DEPTH = 4) plus a hand-written duplicate-code sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_event_queue;

  logic       clock;
  logic       reset;
  logic [1:0] encoded_code;
  logic       encoded_valid;
  logic [1:0] event_code;
  logic       event_valid;
  logic       event_ready;
  logic [2:0] fifo_count;
  logic       overflow_flag;
  logic       overflow_clear;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] c;
    logic       rdy;
    logic       clr;
    logic [2:0] cnt;
    logic       val;
    logic [1:0] code;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  priority_event_queue #(.DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .encoded_code   (encoded_code),
    .encoded_valid  (encoded_valid),
    .event_code     (event_code),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .fifo_count     (fifo_count),
    .overflow_flag  (overflow_flag),
    .overflow_clear (overflow_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input logic rst, input logic v, input logic [1:0] c,
                              input logic rdy, input logic clr, input logic [2:0] cnt,
                              input logic val, input logic [1:0] code, input logic ovf);
    vec_t t;
    t.rst = rst; t.v = v; t.c = c; t.rdy = rdy; t.clr = clr;
    t.cnt = cnt; t.val = val; t.code = code; t.ovf = ovf;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [1:0] c,
                       input logic rdy, input logic clr);
    reset          = rst;
    encoded_valid  = v;
    encoded_code   = c;
    event_ready    = rdy;
    overflow_clear = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; encoded_valid = 1'b0; encoded_code = 2'b00;
    event_ready = 1'b0; overflow_clear = 1'b0;

    //   rst v  c     rdy clr  cnt val code   ovf
    // reset state
    add(1, 0, 2'd0, 0, 0, 3'd0, 0, 2'd0, 0);
    // code 11 held 5 cycles, not consumed: one event only
    add(0, 1, 2'd3, 0, 0, 3'd1, 1, 2'd3, 0);
    add(0, 1, 2'd3, 0, 0, 3'd1, 1, 2'd3, 0);
    add(0, 1, 2'd3, 0, 0, 3'd1, 1, 2'd3, 0);
    add(0, 1, 2'd3, 0, 0, 3'd1, 1, 2'd3, 0);
    add(0, 1, 2'd3, 0, 0, 3'd1, 1, 2'd3, 0);
    add(0, 0, 2'd0, 1, 0, 3'd0, 0, 2'd0, 0);
    // 01,10,11,00 back to back, then drained in order
    add(0, 1, 2'd1, 0, 0, 3'd1, 1, 2'd1, 0);
    add(0, 1, 2'd2, 0, 0, 3'd2, 1, 2'd1, 0);
    add(0, 1, 2'd3, 0, 0, 3'd3, 1, 2'd1, 0);
    add(0, 1, 2'd0, 0, 0, 3'd4, 1, 2'd1, 0);
    add(0, 0, 2'd0, 1, 0, 3'd3, 1, 2'd2, 0);
    add(0, 0, 2'd0, 1, 0, 3'd2, 1, 2'd3, 0);
    add(0, 0, 2'd0, 1, 0, 3'd1, 1, 2'd0, 0);
    add(0, 0, 2'd0, 1, 0, 3'd0, 0, 2'd0, 0);
    // pop on empty does nothing
    add(0, 0, 2'd0, 1, 0, 3'd0, 0, 2'd0, 0);
    // fill across the pointer wrap, then overflow
    add(0, 1, 2'd2, 0, 0, 3'd1, 1, 2'd2, 0);
    add(0, 1, 2'd1, 0, 0, 3'd2, 1, 2'd2, 0);
    add(0, 1, 2'd3, 0, 0, 3'd3, 1, 2'd2, 0);
    add(0, 1, 2'd0, 0, 0, 3'd4, 1, 2'd2, 0);
    add(0, 1, 2'd2, 0, 0, 3'd4, 1, 2'd2, 1);
    // clear together with a drop: drop wins
    add(0, 1, 2'd1, 0, 1, 3'd4, 1, 2'd2, 1);
    // clear alone
    add(0, 1, 2'd1, 0, 1, 3'd4, 1, 2'd2, 0);
    // full, pop and capture together: count stays, head advances
    add(0, 1, 2'd3, 1, 0, 3'd4, 1, 2'd1, 0);
    // drain: new entry sits at the tail
    add(0, 0, 2'd0, 1, 0, 3'd3, 1, 2'd3, 0);
    add(0, 0, 2'd0, 1, 0, 3'd2, 1, 2'd0, 0);
    add(0, 0, 2'd0, 1, 0, 3'd1, 1, 2'd3, 0);
    add(0, 0, 2'd0, 1, 0, 3'd0, 0, 2'd0, 0);
    // push and pop at count 1
    add(0, 1, 2'd2, 0, 0, 3'd1, 1, 2'd2, 0);
    add(0, 1, 2'd1, 1, 0, 3'd1, 1, 2'd1, 0);
    add(0, 0, 2'd0, 1, 0, 3'd0, 0, 2'd0, 0);
    // push into empty FIFO with ready high: no same-cycle pop
    add(0, 1, 2'd0, 1, 0, 3'd1, 1, 2'd0, 0);
    add(0, 1, 2'd0, 0, 0, 3'd1, 1, 2'd0, 0);
    // fill, overflow, then reset mid-operation with traffic present
    add(0, 1, 2'd2, 0, 0, 3'd2, 1, 2'd0, 0);
    add(0, 1, 2'd3, 0, 0, 3'd3, 1, 2'd0, 0);
    add(0, 1, 2'd1, 0, 0, 3'd4, 1, 2'd0, 0);
    add(0, 1, 2'd2, 0, 0, 3'd4, 1, 2'd0, 1);
    add(1, 1, 2'd3, 1, 0, 3'd0, 0, 2'd0, 0);
    // first cycle after reset with valid high captures
    add(0, 1, 2'd3, 0, 0, 3'd1, 1, 2'd3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].c, vecs[i].rdy, vecs[i].clr);
      check("fifo_count", i, 8'(fifo_count), 8'(vecs[i].cnt));
      check("event_valid", i, 8'(event_valid), 8'(vecs[i].val));
      check("overflow_flag", i, 8'(overflow_flag), 8'(vecs[i].ovf));
      if (vecs[i].val || vecs[i].rst) begin
        check("event_code", i, 8'(event_code), 8'(vecs[i].code));
      end
    end

    // Code 11, invalid gap, code 11 again
    drive(1, 0, 2'd0, 0, 0);
    check("dup_reset_count", 100, 8'(fifo_count), 8'd0);
    drive(0, 1, 2'd3, 0, 0);
    check("dup_first_count", 101, 8'(fifo_count), 8'd1);
    drive(0, 0, 2'd0, 0, 0);
    check("dup_gap_count", 102, 8'(fifo_count), 8'd1);
    drive(0, 1, 2'd3, 0, 0);
`ifdef PRIORITY_EVENT_DEDUP_EN
    check("dup_second_count", 103, 8'(fifo_count), 8'd1);
`else
    check("dup_second_count", 103, 8'(fifo_count), 8'd2);
`endif
    check("dup_head", 104, 8'(event_code), 8'd3);
    drive(0, 0, 2'd0, 1, 0);
`ifdef PRIORITY_EVENT_DEDUP_EN
    check("dup_after_pop_count", 105, 8'(fifo_count), 8'd0);
`else
    check("dup_after_pop_count", 105, 8'(fifo_count), 8'd1);
    check("dup_after_pop_head", 106, 8'(event_code), 8'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
